// File: rtl/layer1_act_serializer.sv
// rtl/layer1_act_serializer.sv - ReLU capture bank for layer 1 results, streamed one element per beat
module layer1_act_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int NODES      = 128,
   parameter int IDX_W      = 7
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_WIDTH*NODES-1:0] in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [IDX_W-1:0]            out_index,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        done,
   output logic                        overrun
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NODES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [DATA_WIDTH-1:0] bank [NODES];
   logic                  capture;
   logic                  final_beat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         done    <= final_beat;
         overrun <= in_valid && (state == STREAM);
      end
   end

   // Elements stream from the top index down, so the last beat is always index 0.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      capture    = 1'b0;
      final_beat = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               capture   = 1'b1;
               idx_nxt   = FIRST_IDX;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (idx == '0) begin
                  final_beat = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  idx_nxt = idx - IDX_ONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ReLU on capture: a set sign bit clears the element, otherwise it passes unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NODES; k++) bank[k] <= '0;
      end else if (capture) begin
         for (int k = 0; k < NODES; k++)
            bank[k] <= in_data[DATA_WIDTH*k + DATA_WIDTH-1] ? '0 : in_data[DATA_WIDTH*k +: DATA_WIDTH];
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == STREAM);
   assign out_index = idx;
   assign out_last  = (state == STREAM) && (idx == '0);
   assign out_data  = (state == STREAM) ? bank[idx] : '0;

endmodule

// File: tb/tb_layer1_act_serializer.sv
// tb/tb_layer1_act_serializer.sv - directed bench for the layer 1 activation serializer
module tb_layer1_act_serializer;
   localparam int DW = 8;
   localparam int N  = 128;
   localparam int IW = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW*N-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic [IW-1:0] out_index;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          done;
   logic          overrun;

   int checks_total  = 0;
   int checks_passed = 0;

   logic [DW*N-1:0] vec;
   logic [DW*N-1:0] alt_vec;
   logic [7:0]      exp_d [N];
   int              beat_idx [$];
   logic [7:0]      beat_dat [$];
   bit              beat_last [$];
   int              done_cnt, ovr_cnt, stall_err, done_delay;

   layer1_act_serializer #(.DATA_WIDTH(DW), .NODES(N), .IDX_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .done      (done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_vec(input logic [DW*N-1:0] v);
      in_data  = v;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Drives out_ready and optional in_valid injections, records every transferred beat.
   task automatic run_stream(input bit bp, input int ovr_idx, input bit ovr_final, input int limit);
      int         cyc = 0;
      int         last_cyc = -1;
      int         done_cyc = -1;
      bit         prev_stall = 0;
      logic [7:0] pd = '0;
      logic [IW-1:0] pi = '0;
      beat_idx.delete();
      beat_dat.delete();
      beat_last.delete();
      done_cnt = 0; ovr_cnt = 0; stall_err = 0;
      while (cyc < limit && !(last_cyc >= 0 && cyc > last_cyc + 3)) begin
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (overrun) ovr_cnt++;
         if (prev_stall && (out_data !== pd || out_index !== pi || out_valid !== 1'b1)) stall_err++;
         out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         in_valid  = 1'b0;
         if (out_valid && ((ovr_idx >= 0 && int'(out_index) == ovr_idx) || (ovr_final && out_last))) begin
            in_valid = 1'b1;
            in_data  = alt_vec;
         end
         if (out_valid && out_ready) begin
            beat_idx.push_back(int'(out_index));
            beat_dat.push_back(out_data);
            beat_last.push_back(out_last);
            if (out_last) last_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data;
         pi = out_index;
         step();
         cyc++;
      end
      in_valid   = 1'b0;
      done_delay = done_cyc - last_cyc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      checks_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else checks_passed++;
      checks_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else checks_passed++;
      checks_total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else checks_passed++;
      checks_total++; if (out_index !== 7'd0) $display("FAIL reset_out_index got %0d exp 0", out_index); else checks_passed++;
      checks_total++; if ({out_last, done, overrun} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {out_last, done, overrun}); else checks_passed++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_ramp();
      for (int k = 0; k < N; k++) begin
         vec[8*k +: 8] = 8'(k - 64);
         exp_d[k] = (k >= 64) ? 8'(k - 64) : 8'h00;
      end
      load_vec(vec);
      checks_total++; if (out_valid !== 1'b1 || out_index !== 7'd127 || out_data !== 8'h3F)
         $display("FAIL ramp_first got v=%b idx=%0d d=%h exp v=1 idx=127 d=3f", out_valid, out_index, out_data); else checks_passed++;
      checks_total++; if (in_ready !== 1'b0) $display("FAIL ramp_in_ready got %b exp 0", in_ready); else checks_passed++;
      run_stream(0, -1, 0, 600);
      checks_total++; if (beat_idx.size() !== N) $display("FAIL ramp_count got %0d exp %0d", beat_idx.size(), N); else checks_passed++;
      for (int i = 0; i < beat_idx.size() && i < N; i++) begin
         checks_total++;
         if (beat_idx[i] !== N-1-i || beat_dat[i] !== exp_d[N-1-i] || beat_last[i] !== (i == N-1))
            $display("FAIL ramp_beat%0d got idx=%0d d=%h last=%0d exp idx=%0d d=%h last=%0d", i, beat_idx[i], beat_dat[i], beat_last[i], N-1-i, exp_d[N-1-i], (i == N-1));
         else checks_passed++;
      end
      checks_total++; if (done_cnt !== 1 || done_delay !== 1) $display("FAIL ramp_done got cnt=%0d delay=%0d exp cnt=1 delay=1", done_cnt, done_delay); else checks_passed++;
      checks_total++; if (ovr_cnt !== 0) $display("FAIL ramp_overrun got %0d exp 0", ovr_cnt); else checks_passed++;
   endtask

   task automatic test_boundary();
      for (int k = 0; k < N; k++) begin
         vec[8*k +: 8] = (k % 2 == 1) ? 8'h33 : 8'hAA;
         exp_d[k] = (k % 2 == 1) ? 8'h33 : 8'h00;
      end
      vec[8*127 +: 8] = 8'h7F; exp_d[127] = 8'h7F;
      vec[8*126 +: 8] = 8'h80; exp_d[126] = 8'h00;
      vec[8*125 +: 8] = 8'hFF; exp_d[125] = 8'h00;
      vec[8*124 +: 8] = 8'h00; exp_d[124] = 8'h00;
      vec[8*123 +: 8] = 8'h01; exp_d[123] = 8'h01;
      load_vec(vec);
      run_stream(0, -1, 0, 600);
      checks_total++; if (beat_idx.size() !== N) $display("FAIL bnd_count got %0d exp %0d", beat_idx.size(), N); else checks_passed++;
      for (int i = 0; i < beat_idx.size() && i < N; i++) begin
         checks_total++;
         if (beat_idx[i] !== N-1-i || beat_dat[i] !== exp_d[N-1-i])
            $display("FAIL bnd_beat%0d got idx=%0d d=%h exp idx=%0d d=%h", i, beat_idx[i], beat_dat[i], N-1-i, exp_d[N-1-i]);
         else checks_passed++;
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < N; k++) begin
         vec[8*k +: 8] = 8'(k);
         exp_d[k] = 8'(k);
      end
      load_vec(vec);
      run_stream(1, -1, 0, 900);
      checks_total++; if (beat_idx.size() !== N) $display("FAIL bp_count got %0d exp %0d", beat_idx.size(), N); else checks_passed++;
      for (int i = 0; i < beat_idx.size() && i < N; i++) begin
         checks_total++;
         if (beat_idx[i] !== N-1-i || beat_dat[i] !== exp_d[N-1-i])
            $display("FAIL bp_beat%0d got idx=%0d d=%h exp idx=%0d d=%h", i, beat_idx[i], beat_dat[i], N-1-i, exp_d[N-1-i]);
         else checks_passed++;
      end
      checks_total++; if (stall_err !== 0) $display("FAIL bp_stall_stable got %0d changes exp 0", stall_err); else checks_passed++;
      checks_total++; if (done_cnt !== 1 || done_delay !== 1) $display("FAIL bp_done got cnt=%0d delay=%0d exp cnt=1 delay=1", done_cnt, done_delay); else checks_passed++;
   endtask

   task automatic test_overrun();
      for (int k = 0; k < N; k++) begin
         vec[8*k +: 8] = 8'(127 - k);
         exp_d[k] = 8'(127 - k);
         alt_vec[8*k +: 8] = 8'h7F;
      end
      load_vec(vec);
      run_stream(0, 50, 1, 600);
      checks_total++; if (ovr_cnt !== 2) $display("FAIL ovr_pulses got %0d exp 2", ovr_cnt); else checks_passed++;
      checks_total++; if (beat_idx.size() !== N) $display("FAIL ovr_count got %0d exp %0d", beat_idx.size(), N); else checks_passed++;
      for (int i = 0; i < beat_idx.size() && i < N; i++) begin
         checks_total++;
         if (beat_idx[i] !== N-1-i || beat_dat[i] !== exp_d[N-1-i])
            $display("FAIL ovr_beat%0d got idx=%0d d=%h exp idx=%0d d=%h", i, beat_idx[i], beat_dat[i], N-1-i, exp_d[N-1-i]);
         else checks_passed++;
      end
      checks_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL ovr_idle_after got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else checks_passed++;
      checks_total++; if (done_cnt !== 1) $display("FAIL ovr_done got %0d exp 1", done_cnt); else checks_passed++;
   endtask

   task automatic test_midreset();
      bit found = 0;
      for (int k = 0; k < N; k++) vec[8*k +: 8] = 8'(k - 64);
      load_vec(vec);
      out_ready = 1'b1;
      for (int c = 0; c < 300 && !found; c++) begin
         if (out_valid && out_index == 7'd80) found = 1;
         else step();
      end
      checks_total++; if (!found) $display("FAIL mrst_reach80 got timeout exp index 80"); else checks_passed++;
      reset = 1'b1;
      #1;
      checks_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || out_index !== 7'd0 || out_last !== 1'b0)
         $display("FAIL mrst_outputs got v=%b rdy=%b d=%h idx=%0d last=%b exp v=0 rdy=1 d=00 idx=0 last=0", out_valid, in_ready, out_data, out_index, out_last);
      else checks_passed++;
      step();
      checks_total++; if (done !== 1'b0 || overrun !== 1'b0) $display("FAIL mrst_done_in_reset got done=%b ovr=%b exp 0 0", done, overrun); else checks_passed++;
      reset = 1'b0;
      step();
      checks_total++; if (done !== 1'b0 || out_valid !== 1'b0) $display("FAIL mrst_after_release got done=%b v=%b exp 0 0", done, out_valid); else checks_passed++;
      for (int k = 0; k < N; k++) begin
         vec[8*k +: 8] = 8'(127 - k);
         exp_d[k] = 8'(127 - k);
      end
      load_vec(vec);
      run_stream(0, -1, 0, 600);
      checks_total++; if (beat_idx.size() !== N) $display("FAIL mrst_count got %0d exp %0d", beat_idx.size(), N); else checks_passed++;
      for (int i = 0; i < beat_idx.size() && i < N; i++) begin
         checks_total++;
         if (beat_idx[i] !== N-1-i || beat_dat[i] !== exp_d[N-1-i])
            $display("FAIL mrst_beat%0d got idx=%0d d=%h exp idx=%0d d=%h", i, beat_idx[i], beat_dat[i], N-1-i, exp_d[N-1-i]);
         else checks_passed++;
      end
   endtask

   task automatic test_back_to_back();
      bit found = 0;
      for (int k = 0; k < N; k++) vec[8*k +: 8] = 8'(k);
      load_vec(vec);
      out_ready = 1'b1;
      for (int c = 0; c < 300 && !found; c++) begin
         if (out_valid && out_last) found = 1;
         else step();
      end
      checks_total++; if (!found) $display("FAIL b2b_last got timeout exp last beat"); else checks_passed++;
      step();
      checks_total++; if (in_ready !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL b2b_bubble got rdy=%b done=%b v=%b exp 1 1 0", in_ready, done, out_valid); else checks_passed++;
      for (int k = 0; k < N; k++) begin
         vec[8*k +: 8] = 8'(k - 64);
         exp_d[k] = (k >= 64) ? 8'(k - 64) : 8'h00;
      end
      load_vec(vec);
      checks_total++; if (out_valid !== 1'b1 || out_index !== 7'd127 || out_data !== 8'h3F)
         $display("FAIL b2b_second_first got v=%b idx=%0d d=%h exp v=1 idx=127 d=3f", out_valid, out_index, out_data); else checks_passed++;
      run_stream(0, -1, 0, 600);
      checks_total++; if (beat_idx.size() !== N) $display("FAIL b2b_count got %0d exp %0d", beat_idx.size(), N); else checks_passed++;
      for (int i = 0; i < beat_idx.size() && i < N; i++) begin
         checks_total++;
         if (beat_idx[i] !== N-1-i || beat_dat[i] !== exp_d[N-1-i])
            $display("FAIL b2b_beat%0d got idx=%0d d=%h exp idx=%0d d=%h", i, beat_idx[i], beat_dat[i], N-1-i, exp_d[N-1-i]);
         else checks_passed++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      alt_vec   = '0;
      vec       = '0;
      test_reset();
      test_ramp();
      test_boundary();
      test_backpressure();
      test_overrun();
      test_midreset();
      test_back_to_back();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
